// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  morse_pkg
//  Shared definitions for the Morse encoder/decoder pair: the letter code
//  type, the decoder state encoding, the element-store depth, and the
//  letter lookup table. Both sides read the table from here.
//  Revision: 1.0  initial release
// ============================================================================
package morse_pkg;

    localparam int MAX_ELEMENTS = 4;

    typedef enum logic [2:0] {
        LETTER_A = 3'd0,
        LETTER_B = 3'd1,
        LETTER_C = 3'd2,
        LETTER_D = 3'd3,
        LETTER_E = 3'd4,
        LETTER_F = 3'd5,
        LETTER_G = 3'd6,
        LETTER_H = 3'd7
    } letter_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } state_t;

    typedef struct packed {
        logic    valid;
        letter_t letter;
    } lookup_t;

    // Elements are stored with the first one at bit count-1; a 0 is a dot
    // and a 1 is a dash. Bits above count-1 are masked off before matching.
    function automatic lookup_t morse_lookup(input logic [2:0] count,
                                             input logic [3:0] pattern);
        lookup_t    r;
        logic [3:0] mask;
        logic [3:0] key;
        // For count = 4 the shift yields 0 and the subtraction wraps to 4'b1111.
        mask     = (4'b0001 << count) - 4'b0001;
        key      = pattern & mask;
        r.valid  = 1'b1;
        r.letter = LETTER_A;
        case ({count, key})
            7'b010_0001: r.letter = LETTER_A;
            7'b100_1000: r.letter = LETTER_B;
            7'b100_1010: r.letter = LETTER_C;
            7'b011_0100: r.letter = LETTER_D;
            7'b001_0000: r.letter = LETTER_E;
            7'b100_0010: r.letter = LETTER_F;
            7'b011_0110: r.letter = LETTER_G;
            7'b100_0000: r.letter = LETTER_H;
            default:     r.valid  = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morse_decoder.sv
`default_nettype none
// ============================================================================
//  morse_decoder
//  Reassembles the strobed serial dot/dash stream from the Morse encoder and
//  reports the letter (A..H = 0..7) at each inter-letter gap, or flags a
//  malformed letter.
//
//  Ports
//    ClockIn      in   rising-edge clock
//    Reset        in   synchronous, active-high
//    DotDashIn    in   serial bit, 1 = mark, 0 = space
//    NewBitIn     in   strobe; DotDashIn is sampled only when high
//    LetterOut    out  last successfully decoded letter code (held)
//    LetterValid  out  one-cycle pulse on a good letter
//    ErrorOut     out  one-cycle pulse on a malformed letter
//    Busy         out  high while a letter is in progress
//  Revision: 1.0  initial release
// ============================================================================
module morse_decoder
    import morse_pkg::*;
#(
    parameter int DASH_LEN = 3
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       DotDashIn,
    input  logic       NewBitIn,
    output logic [2:0] LetterOut,
    output logic       LetterValid,
    output logic       ErrorOut,
    output logic       Busy
);

    localparam int               RUN_W    = $clog2(DASH_LEN + 2);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_DASH = RUN_W'(DASH_LEN);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(DASH_LEN + 1);
    localparam logic [2:0]       CNT_MAX  = 3'(MAX_ELEMENTS);

    state_t           state, state_next;
    logic [RUN_W-1:0] run, run_next;
    logic [3:0]       pattern, pattern_next;
    logic [2:0]       count, count_next;
    logic             bad, bad_next;
    logic [2:0]       letter_next;
    logic             valid_next, error_next;
    logic             elem, elem_bad;
    lookup_t          hit;

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state       <= ST_IDLE;
            run         <= '0;
            pattern     <= '0;
            count       <= '0;
            bad         <= 1'b0;
            LetterOut   <= '0;
            LetterValid <= 1'b0;
            ErrorOut    <= 1'b0;
        end else begin
            state       <= state_next;
            run         <= run_next;
            pattern     <= pattern_next;
            count       <= count_next;
            bad         <= bad_next;
            LetterOut   <= letter_next;
            LetterValid <= valid_next;
            ErrorOut    <= error_next;
        end
    end

    always_comb begin
        state_next   = state;
        run_next     = run;
        pattern_next = pattern;
        count_next   = count;
        bad_next     = bad;
        letter_next  = LetterOut;
        valid_next   = 1'b0;
        error_next   = 1'b0;

        // A mark run is a dash only at exactly DASH_LEN; the saturating
        // counter keeps over-long marks from wrapping back to a "dot".
        elem     = (run == RUN_DASH);
        elem_bad = (run != RUN_ONE) && (run != RUN_DASH);
        hit      = morse_lookup(count, pattern);

        if (NewBitIn) begin
            case (state)
                ST_IDLE: begin
                    if (DotDashIn) begin
                        state_next   = ST_MARK;
                        run_next     = RUN_ONE;
                        pattern_next = '0;
                        count_next   = '0;
                        bad_next     = 1'b0;
                    end
                end
                ST_MARK: begin
                    if (DotDashIn) begin
                        if (run != RUN_MAX) begin
                            run_next = run + RUN_ONE;
                        end
                    end else begin
                        state_next = ST_SPACE;
                        if (elem_bad) begin
                            bad_next = 1'b1;
                        end
                        // Overflow freezes the store and marks the letter bad.
                        if (count == CNT_MAX) begin
                            bad_next = 1'b1;
                        end else begin
                            pattern_next = {pattern[2:0], elem};
                            count_next   = count + 3'd1;
                        end
                    end
                end
                ST_SPACE: begin
                    if (DotDashIn) begin
                        state_next = ST_MARK;
                        run_next   = RUN_ONE;
                    end else begin
                        state_next = ST_IDLE;
                        if (bad || !hit.valid) begin
                            error_next = 1'b1;
                        end else begin
                            valid_next  = 1'b1;
                            letter_next = hit.letter;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign Busy = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_decoder.sv
`default_nettype none
// ============================================================================
//  tb_morse_decoder
//  Scoreboard bench: each stimulus letter pushes its expected outcome; a
//  negedge monitor pops and compares whenever the decoder pulses.
//  Revision: 1.0  initial release
// ============================================================================
module tb_morse_decoder;

    logic       ClockIn = 1'b0;
    logic       Reset;
    logic       DotDashIn;
    logic       NewBitIn;
    logic [2:0] LetterOut;
    logic       LetterValid;
    logic       ErrorOut;
    logic       Busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit         is_err;
        logic [2:0] letter;
    } exp_t;

    exp_t       sb_q[$];
    logic [2:0] last_letter = 3'd0;

    morse_decoder #(.DASH_LEN(3)) dut (
        .ClockIn    (ClockIn),
        .Reset      (Reset),
        .DotDashIn  (DotDashIn),
        .NewBitIn   (NewBitIn),
        .LetterOut  (LetterOut),
        .LetterValid(LetterValid),
        .ErrorOut   (ErrorOut),
        .Busy       (Busy)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge ClockIn) begin
        if (Reset === 1'b0) begin
            check_value("exclusive", {31'd0, LetterValid & ErrorOut}, 32'd0);
            if (LetterValid || ErrorOut) begin
                if (sb_q.size() == 0) begin
                    check_value("unexpected_pulse", {31'd0, LetterValid | ErrorOut}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check_value("pulse_kind_err", {31'd0, ErrorOut}, {31'd0, e.is_err});
                    check_value("pulse_kind_ok", {31'd0, LetterValid}, {31'd0, !e.is_err});
                    check_value("letter_out", {29'd0, LetterOut}, {29'd0, e.letter});
                end
            end
        end
    end

    task automatic expect_letter(input logic [2:0] code);
        exp_t e;
        e.is_err = 1'b0;
        e.letter = code;
        last_letter = code;
        sb_q.push_back(e);
    endtask

    task automatic expect_error();
        exp_t e;
        e.is_err = 1'b1;
        e.letter = last_letter;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at a negedge one cycle later.
    task automatic send_bit(input logic b);
        DotDashIn = b;
        NewBitIn  = 1'b1;
        @(negedge ClockIn);
        NewBitIn  = 1'b0;
    endtask

    // Strobe spacing is 'gap' cycles. When 'is_letter' is set, the last bit is
    // the terminating 0, so the pulse and the Busy fall are checked right after.
    task automatic send_stream(input string s, input int gap, input bit is_letter);
        for (int i = 0; i < s.len(); i++) begin
            send_bit(s[i] == "1");
            if (i == 0) begin
                check_value("busy_rise", {31'd0, Busy}, {31'd0, s[0] == "1"});
            end
            if (is_letter && i == s.len() - 1) begin
                check_value("pulse_timing", {31'd0, LetterValid | ErrorOut}, 32'd1);
                check_value("busy_fall", {31'd0, Busy}, 32'd0);
            end
            repeat (gap - 1) @(negedge ClockIn);
        end
    endtask

    task automatic drain();
        repeat (3) @(negedge ClockIn);
        check_value("scoreboard_drain", sb_q.size(), 32'd0);
    endtask

    // Reference Morse table built independently of the RTL package.
    function automatic string morse_stream(input int code);
        string sym, out;
        case (code)
            0: sym = ".-";
            1: sym = "-...";
            2: sym = "-.-.";
            3: sym = "-..";
            4: sym = ".";
            5: sym = "..-.";
            6: sym = "--.";
            default: sym = "....";
        endcase
        out = "";
        for (int i = 0; i < sym.len(); i++) begin
            out = {out, (sym[i] == "-") ? "1110" : "10"};
        end
        return {out, "0"};
    endfunction

    initial begin
        Reset     = 1'b1;
        DotDashIn = 1'b0;
        NewBitIn  = 1'b0;
        repeat (3) @(negedge ClockIn);
        check_value("rst_letter", {29'd0, LetterOut}, 32'd0);
        check_value("rst_valid", {31'd0, LetterValid}, 32'd0);
        check_value("rst_error", {31'd0, ErrorOut}, 32'd0);
        check_value("rst_busy", {31'd0, Busy}, 32'd0);
        Reset = 1'b0;
        @(negedge ClockIn);

        // Idle zeros produce nothing.
        send_stream("0000", 1, 1'b0);
        check_value("idle_busy", {31'd0, Busy}, 32'd0);

        // A with back-to-back strobes.
        expect_letter(3'd0);
        send_stream("1011100", 1, 1'b1);
        drain();

        // C then E, strobes every 4 cycles.
        expect_letter(3'd2);
        send_stream("1110101110100", 4, 1'b1);
        expect_letter(3'd4);
        send_stream("100", 4, 1'b1);
        drain();

        // Run of length 2.
        expect_error();
        send_stream("1100", 2, 1'b1);
        drain();
        check_value("letter_held", {29'd0, LetterOut}, 32'd4);

        // Five dots: overflow.
        expect_error();
        send_stream("10101010100", 1, 1'b1);
        // Dash-dash: not in the table.
        expect_error();
        send_stream("111011100", 1, 1'b1);
        // Over-long mark saturates and reads as bad.
        expect_error();
        send_stream("11111111100", 1, 1'b1);
        drain();

        // Reset mid-letter discards the partial letter.
        send_stream("1110", 1, 1'b0);
        Reset = 1'b1;
        DotDashIn = 1'b1;
        NewBitIn  = 1'b1;
        @(negedge ClockIn);
        Reset    = 1'b0;
        NewBitIn = 1'b0;
        check_value("mid_reset_busy", {31'd0, Busy}, 32'd0);
        expect_letter(3'd4);
        send_stream("100", 1, 1'b1);
        drain();

        // Strobe held low while DotDashIn toggles: nothing changes.
        send_stream("10", 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            DotDashIn = i[0];
            @(negedge ClockIn);
        end
        check_value("nostrobe_busy", {31'd0, Busy}, 32'd1);
        check_value("nostrobe_letter", {29'd0, LetterOut}, 32'd4);
        expect_letter(3'd4);
        send_stream("0", 1, 1'b1);
        drain();

        // Encoder-style streams for every letter, one strobe per 8 cycles.
        for (int c = 0; c < 8; c++) begin
            expect_letter(3'(c));
            send_stream(morse_stream(c), 8, 1'b1);
        end
        drain();

        // Same letters reversed, back-to-back strobes.
        for (int c = 7; c >= 0; c--) begin
            expect_letter(3'(c));
            send_stream(morse_stream(c), 1, 1'b1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
`default_nettype wire
